// File: rtl/alu_operand_seq.sv
// Registered A/B operand source for the ALU experiment: corner-case table
// driven by switch select, manual step, timed auto-step or an LFSR.
module alu_operand_seq #(
    parameter int          WIDTH     = 32,
    parameter int          AUTO_DIV  = 50_000_000,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_2468
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic [2:0]       sel_sw,
    input  logic             step_in,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [2:0]       idx,
    output logic             upd
);
    localparam int                 CNT_W    = $clog2(AUTO_DIV);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(AUTO_DIV - 1);
    localparam logic [31:0]        SEED     = (LFSR_SEED == 32'd0) ? 32'd1 : LFSR_SEED;
    localparam logic [31:0]        TAPS     = 32'h8020_0003;
    localparam logic [WIDTH-1:0]   MSB      = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0]   MAXP     = ~MSB;
    localparam logic [WIDTH-1:0]   ONES     = '1;
    localparam logic [31:0]        K1B      = 32'h0000_0607;
    localparam logic [31:0]        K7A      = 32'h1234_5678;
    localparam logic [31:0]        K7B      = 32'h3333_2222;

    typedef enum logic [1:0] {
        MODE_DIRECT = 2'b00,
        MODE_STEP   = 2'b01,
        MODE_AUTO   = 2'b10,
        MODE_RANDOM = 2'b11
    } mode_e;

    function automatic logic [WIDTH-1:0] tab_a(input logic [2:0] i);
        case (i)
            3'd0:    tab_a = '0;
            3'd1:    tab_a = WIDTH'(3);
            3'd2:    tab_a = MSB;
            3'd3:    tab_a = MAXP;
            3'd4:    tab_a = ONES;
            3'd5:    tab_a = MSB;
            3'd6:    tab_a = ONES;
            default: tab_a = K7A[WIDTH-1:0];
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] tab_b(input logic [2:0] i);
        case (i)
            3'd0:    tab_b = '0;
            3'd1:    tab_b = K1B[WIDTH-1:0];
            3'd2:    tab_b = MSB;
            3'd3:    tab_b = MAXP;
            3'd4:    tab_b = ONES;
            3'd5:    tab_b = ONES;
            3'd6:    tab_b = MSB;
            default: tab_b = K7B[WIDTH-1:0];
        endcase
    endfunction

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        lfsr_next = s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
    endfunction

    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]       idx_q, idx_d, nxt_idx;
    logic             upd_q, upd_d, step_prev_q, step_prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      lfsr_q, lfsr_d, lfsr_s1, lfsr_s2;
    logic             step_rise, load;

    assign step_rise = step_in & ~step_prev_q;

    always_comb begin
        a_d         = a_q;
        b_d         = b_q;
        idx_d       = idx_q;
        lfsr_d      = lfsr_q;
        upd_d       = 1'b0;
        step_prev_d = step_in;
        // cnt only survives while staying in AUTO, so any mode change clears it
        cnt_d       = '0;
        nxt_idx     = idx_q + 3'd1;
        load        = 1'b0;
        lfsr_s1     = lfsr_next(lfsr_q);
        lfsr_s2     = lfsr_next(lfsr_s1);
        case (mode_e'(mode))
            MODE_DIRECT: begin
                nxt_idx = sel_sw;
                load    = (sel_sw != idx_q);
            end
            MODE_STEP: begin
                load = step_rise;
            end
            MODE_AUTO: begin
                if (cnt_q == CNT_LAST) begin
                    load = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                if (step_rise) begin
                    lfsr_d = lfsr_s2;
                    a_d    = lfsr_s1[WIDTH-1:0];
                    b_d    = lfsr_s2[WIDTH-1:0];
                    upd_d  = 1'b1;
                end
            end
        endcase
        if (load) begin
            idx_d = nxt_idx;
            a_d   = tab_a(nxt_idx);
            b_d   = tab_b(nxt_idx);
            upd_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q         <= '0;
            b_q         <= '0;
            idx_q       <= 3'd0;
            upd_q       <= 1'b0;
            cnt_q       <= '0;
            step_prev_q <= 1'b0;
            lfsr_q      <= SEED;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            idx_q       <= idx_d;
            upd_q       <= upd_d;
            cnt_q       <= cnt_d;
            step_prev_q <= step_prev_d;
            lfsr_q      <= lfsr_d;
        end
    end

    assign A   = a_q;
    assign B   = b_q;
    assign idx = idx_q;
    assign upd = upd_q;
endmodule
